dwt_pair_packer: RTL and testbench

- Upstream neighbour of the 1D lifting processing unit: converts a one-sample-per-beat pixel stream into the {odd, even} pair stream that unit consumes.
- Preserves the sof/eol framing, applies symmetric extension when a line has odd length, and registers the output.
- Sits between the line/column reader and the horizontal or vertical lifting stage.

---
 rtl/dwt_pair_packer.sv | 118 +++++++++++
 tb/tb_dwt_pair_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dwt_pair_packer.sv
// Packs a one-sample-per-beat line stream into {odd, even} pairs for the 1D lifting stage.
// Keeps sof/eol framing, mirrors the tail of odd-length lines and registers the pair output.
module dwt_pair_packer #(
    parameter int unsigned DataWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     s_ready_o,
    input  logic                     s_valid_i,
    input  logic                     s_sof_i,
    input  logic                     s_eol_i,
    input  logic [DataWidth-1:0]     s_data_i,
    input  logic                     m_ready_i,
    output logic                     m_valid_o,
    output logic                     m_sof_o,
    output logic                     m_eol_o,
    output logic [2*DataWidth-1:0]   m_data_o,
    output logic                     drop_o
);

    localparam int unsigned PairWidth = 2 * DataWidth;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t                 state;
    logic [DataWidth-1:0]   even_reg;
    logic [DataWidth-1:0]   prev_even;
    logic                   sof_reg;
    logic                   first_in_line;

    logic                   accept_c;
    logic                   restart_c;
    logic                   line_start_c;
    logic                   emit_c;
    logic                   drop_c;
    logic [PairWidth-1:0]   emit_data_c;
    logic                   emit_sof_c;

    // Ready depends only on the output register, never on the incoming beat.
    assign s_ready_o = ~m_valid_o | m_ready_i;
    assign accept_c  = s_valid_i & s_ready_o;

    // A beat is handled as an even sample in EVEN, or when sof breaks a pending pair.
    always_comb begin
        restart_c    = 1'b0;
        line_start_c = 1'b0;
        emit_c       = 1'b0;
        drop_c       = 1'b0;
        emit_data_c  = '0;
        emit_sof_c   = 1'b0;

        restart_c    = (state == EVEN) || s_sof_i;
        line_start_c = first_in_line || s_sof_i;
        drop_c       = accept_c && (state == ODD) && s_sof_i;

        if (restart_c) begin
            emit_c      = accept_c && s_eol_i;
            // Length-1 lines duplicate the sample; longer odd lines mirror the previous even.
            emit_data_c = {(line_start_c ? s_data_i : prev_even), s_data_i};
            emit_sof_c  = s_sof_i;
        end else begin
            emit_c      = accept_c;
            emit_data_c = {s_data_i, even_reg};
            emit_sof_c  = sof_reg;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= EVEN;
            even_reg      <= '0;
            prev_even     <= '0;
            sof_reg       <= 1'b0;
            first_in_line <= 1'b1;
            m_valid_o     <= 1'b0;
            m_sof_o       <= 1'b0;
            m_eol_o       <= 1'b0;
            m_data_o      <= '0;
            drop_o        <= 1'b0;
        end else begin
            drop_o <= drop_c;

            // Output register: load on emit, otherwise drain on downstream ready.
            if (emit_c) begin
                m_valid_o <= 1'b1;
                m_data_o  <= emit_data_c;
                m_sof_o   <= emit_sof_c;
                m_eol_o   <= s_eol_i;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end

            if (accept_c) begin
                if (restart_c) begin
                    prev_even <= s_data_i;
                    if (s_eol_i) begin
                        state         <= EVEN;
                        first_in_line <= 1'b1;
                    end else begin
                        state         <= ODD;
                        even_reg      <= s_data_i;
                        sof_reg       <= s_sof_i;
                        first_in_line <= 1'b0;
                    end
                end else begin
                    state <= EVEN;
                    if (s_eol_i) begin
                        first_in_line <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dwt_pair_packer.sv
// Directed bench for dwt_pair_packer: expected pairs are queued as beats are driven
// and compared when the DUT hands a pair downstream.
module tb_dwt_pair_packer;

    localparam int unsigned DW = 16;

    typedef struct packed {
        logic [2*DW-1:0] data;
        logic            sof;
        logic            eol;
    } pair_t;

    logic            clk;
    logic            rst_n;
    logic            s_ready;
    logic            s_valid;
    logic            s_sof;
    logic            s_eol;
    logic [DW-1:0]   s_data;
    logic            m_ready;
    logic            m_valid;
    logic            m_sof;
    logic            m_eol;
    logic [2*DW-1:0] m_data;
    logic            drop;

    int checks = 0;
    int errors = 0;
    pair_t exp_q[$];

    dwt_pair_packer #(.DataWidth(DW)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .s_ready_o (s_ready),
        .s_valid_i (s_valid),
        .s_sof_i   (s_sof),
        .s_eol_i   (s_eol),
        .s_data_i  (s_data),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_sof_o   (m_sof),
        .m_eol_o   (m_eol),
        .m_data_o  (m_data),
        .drop_o    (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] odd, input logic [DW-1:0] even,
                        input logic sof, input logic eol);
        pair_t p;
        p.data = {odd, even};
        p.sof  = sof;
        p.eol  = eol;
        exp_q.push_back(p);
    endtask

    // Drive one beat and wait (bounded) until it is accepted; returns 1 ns after that edge.
    task automatic send(input logic [DW-1:0] d, input logic sof, input logic eol);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        s_eol   = eol;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("accept_timeout", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: a transfer happens at the next rising edge whenever valid & ready.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pair", 64'(m_data), 64'd0);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                check("pair_data", 64'(m_data), 64'(e.data));
                check("pair_sof",  64'(m_sof),  64'(e.sof));
                check("pair_eol",  64'(m_eol),  64'(e.eol));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_eol   = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data",  64'(m_data),  64'd0);
        check("rst_m_sof",   64'(m_sof),   64'd0);
        check("rst_m_eol",   64'(m_eol),   64'd0);
        check("rst_drop",    64'(drop),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Even-length line 0..7 in Q6.10 at full rate, one-cycle latency after each odd beat.
        for (int i = 0; i < 8; i += 2) begin
            push(16'((i + 1) << 10), 16'(i << 10), i == 0, i == 6);
        end
        for (int i = 0; i < 8; i++) begin
            send(16'(i << 10), i == 0, i == 7);
            if (i % 2 == 1) begin
                check("lat_valid", 64'(m_valid), 64'd1);
                check("lat_data",  64'(m_data),  64'({16'(i << 10), 16'((i - 1) << 10)}));
            end
        end
        idle(2);
        check("idle_valid_low", 64'(m_valid), 64'd0);

        // Odd-length line: tail mirrors the previous even sample.
        push(16'd20, 16'd10, 1'b1, 1'b0);
        push(16'd40, 16'd30, 1'b0, 1'b0);
        push(16'd30, 16'd50, 1'b0, 1'b1);
        send(16'd10, 1'b1, 1'b0);
        send(16'd20, 1'b0, 1'b0);
        idle(3);
        send(16'd30, 1'b0, 1'b0);
        send(16'd40, 1'b0, 1'b0);
        send(16'd50, 1'b0, 1'b1);
        idle(2);

        // Length-1 line.
        push(16'hFFFB, 16'hFFFB, 1'b1, 1'b1);
        send(16'hFFFB, 1'b1, 1'b1);
        idle(2);

        // Backpressure: first pair stalls for 5 cycles while the next beat waits.
        push(16'h0022, 16'h0021, 1'b1, 1'b0);
        push(16'h0024, 16'h0023, 1'b0, 1'b0);
        push(16'h0026, 16'h0025, 1'b0, 1'b1);
        send(16'h0021, 1'b1, 1'b0);
        m_ready = 1'b0;
        send(16'h0022, 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 16'h0023;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(s_ready), 64'd0);
            check("bp_hold_data", 64'(m_data),  64'h0022_0021);
            check("bp_hold_vld",  64'(m_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        send(16'h0023, 1'b0, 1'b0);
        send(16'h0024, 1'b0, 1'b0);
        send(16'h0025, 1'b0, 1'b0);
        send(16'h0026, 1'b0, 1'b1);
        idle(2);

        // sof on an odd-position beat drops the pending even value 7.
        push(16'd101, 16'd100, 1'b1, 1'b1);
        send(16'd7, 1'b1, 1'b0);
        check("no_drop_yet", 64'(drop), 64'd0);
        send(16'd100, 1'b1, 1'b0);
        check("drop_pulse", 64'(drop), 64'd1);
        send(16'd101, 1'b0, 1'b1);
        check("drop_cleared", 64'(drop), 64'd0);
        idle(2);

        // Asynchronous reset with a pair pending downstream.
        send(16'h0300, 1'b1, 1'b0);
        m_ready = 1'b0;
        send(16'h0400, 1'b0, 1'b0);
        check("pend_valid", 64'(m_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", 64'(m_valid), 64'd0);
        check("async_data",  64'(m_data),  64'd0);
        check("async_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        push(16'h0700, 16'h0600, 1'b1, 1'b0);
        push(16'h0600, 16'h0800, 1'b0, 1'b1);
        send(16'h0600, 1'b1, 1'b0);
        send(16'h0700, 1'b0, 1'b0);
        send(16'h0800, 1'b0, 1'b1);
        idle(3);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
